seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle unsigned integer divider: the subtract-side counterpart to the ripple adder in the execute datapath. It computes quotient and remainder by restoring division, one quotient bit per clock, using a WIDTH+1-bit trial subtraction (remainder minus divisor, borrow-out selects restore). It sits beside the ALU in the execute stage and serves UDIV. The pipeline stalls on `busy` and consumes results on `done`.

## Interface
- `WIDTH`, 64: operand and result width; must be >= 2.
- `delay`, 50: gate delay in ps for primitive gates in the subtractor path; no effect on cycle behaviour.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; clears all state immediately.
- `start`  in  1  request; sampled on a rising edge while not busy.
- `dividend`  in  WIDTH  unsigned numerator; captured with an accepted `start`.
- `divisor`  in  WIDTH  unsigned denominator; captured with an accepted `start`.
- `busy`  out  1  division in progress; `start` is ignored while high.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `quotient`  out  WIDTH  result; held until the next accepted `start`.
- `remainder`  out  WIDTH  result; held until the next accepted `start`.
- `div_by_zero`  out  1  set with `done` when divisor was 0; held with the results.

## Operation
- States:
  - IDLE: after reset.
  - RUN: iterating.
  - FIN: `done` cycle.
- IDLE or FIN, `start`=1:
  - Capture the operands.
  - Clear `quotient`, `remainder` and `div_by_zero`.
  - Load the iteration counter with WIDTH.
  - Go to RUN.
- FIN, `start`=0: go to IDLE.
- RUN, each step:
  - Partial remainder R is shifted left by one and the next dividend bit (MSB first) enters at bit 0.
  - Trial T = R − divisor, computed at WIDTH+1 bits.
  - No borrow: R = T and the quotient bit is 1.
  - Borrow: R is kept (restored) and the quotient bit is 0.
  - The counter decrements.
  - When the counter reaches 0, the results register and the state goes to FIN.
- Divisor = 0:
  - Skip iteration.
  - Go straight to FIN on the next edge with `quotient`=0, `remainder`=dividend, `div_by_zero`=1. This matches ARM UDIV, which returns 0.
- `start` while in RUN: ignored. Operands and progress are unaffected.
- Operands may change after acceptance without affecting the result.
- `reset_n` low at any time, including mid-RUN:
  - Outputs and state clear asynchronously.
  - The in-flight division is abandoned and no `done` is produced.
  - Operation resumes in IDLE on the first edge after release.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - State IDLE, counter 0.
- `start` accepted at edge k with a nonzero divisor:
  - `busy` is high from edge k to edge k+WIDTH.
  - `done` is high for exactly the cycle after edge k+WIDTH.
  - Results are valid from edge k+WIDTH.
  - Latency is WIDTH cycles.
- Divisor = 0: `busy` is high for one cycle after edge k. `done` follows at edge k+1.
- `busy` and `done` are never high together.
- Back-to-back:
  - `start` during the `done` cycle is accepted.
  - `busy` rises at that edge and `done` falls.
  - The previous results stay visible only through the `done` cycle, then clear.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Reset: hold `reset_n`=0 with `start`=1 -> all outputs 0, no `done`. After release, the first `start` is accepted normally.
- WIDTH=64, 100 / 7, `start` at edge k:
  - `busy` is high for 64 cycles.
  - `done` pulses at edge k+64 with `quotient`=14, `remainder`=2, `div_by_zero`=0.
  - Results hold 10 cycles later.
- Boundaries (WIDTH=64):
  - 0xFFFF_FFFF_FFFF_FFFF / 1 -> q=0xFFFF_FFFF_FFFF_FFFF, r=0.
  - 5 / 9 -> q=0, r=5.
  - 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> q=0, r=0x8000_0000_0000_0000. This checks the WIDTH+1 trial width.
- Divide by zero: 1234 / 0 -> `done` at edge k+1, q=0, r=1234, `div_by_zero`=1. A following 10 / 3 -> q=3, r=1, `div_by_zero`=0.
- Ignored and back-to-back `start`, 50 / 5:
  - Pulse `start` with 9 / 2 at k+10 -> ignored; result is still q=10, r=0.
  - `start` 9 / 2 in the `done` cycle -> accepted. The next `done` comes 64 edges later with q=4, r=1.
- Reset mid-run: 1000 / 3, drop `reset_n` at k+20 -> outputs are 0 immediately and no `done` ever appears for it. A new 9 / 3 after release -> q=3, r=0.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider for the execute stage.
// It produces one quotient bit per clock and raises a one-cycle done pulse.
module seq_divider #(
  parameter int WIDTH = 64,
  parameter int delay = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_divider: WIDTH must be >= 2");
  end
  if (delay < 0) begin : g_bad_delay
    $error("seq_divider: delay must be non-negative");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] work;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] work_next;
  logic             accept;
  logic             zero_div;
  logic             last_step;

  assign accept    = start && (state != RUN);
  assign zero_div  = (dvs == '0);
  assign last_step = (count == CW'(1));

  // The partial remainder stays below the divisor, so the top bit of the
  // wrapped WIDTH+1-bit difference is exactly the borrow-out.
  assign trial     = {rem, work[WIDTH-1]} - {1'b0, dvs};
  assign borrow    = trial[WIDTH];
  assign rem_next  = borrow ? {rem[WIDTH-2:0], work[WIDTH-1]} : trial[WIDTH-1:0];
  assign work_next = {work[WIDTH-2:0], ~borrow};

  assign busy = (state == RUN);
  assign done = (state == FIN);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next-state defaults to the current state first so that no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (zero_div || last_step) state_next = FIN;
      FIN:     state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      work        <= '0;
      dvs         <= '0;
      rem         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      count       <= COUNT_LOAD;
      work        <= dividend;
      dvs         <= divisor;
      rem         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      if (zero_div) begin
        count       <= '0;
        quotient    <= '0;
        remainder   <= work;
        div_by_zero <= 1'b1;
      end else begin
        count <= count - CW'(1);
        work  <= work_next;
        rem   <= rem_next;
        if (last_step) begin
          quotient  <= work_next;
          remainder <= rem_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=64: latency, boundaries,
// divide-by-zero, ignored/back-to-back start and mid-run reset.
module tb_seq_divider;

  localparam int W = 64;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(W), .delay(50)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive operands and a one-cycle start; returns at #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Steps edges until done is seen (bounded); lat counts edges since the start edge.
  task automatic wait_done(input int lat0, output int lat, output int nbusy, output int overlap);
    lat     = lat0;
    nbusy   = 0;
    overlap = 0;
    if (busy === 1'b1) nbusy++;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1 && done !== 1'b1) nbusy++;
      if (busy === 1'b1 && done === 1'b1) overlap++;
    end
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez);
    int lat, nbusy, overlap;
    start_op(a, b);
    wait_done(0, lat, nbusy, overlap);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    check({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
  endtask

  initial begin
    int lat, nbusy, overlap, seen_done;
    reset_n  = 1'b0;
    start    = 1'b1;
    dividend = 64'd100;
    divisor  = 64'd7;

    // Reset held with start asserted: nothing may move.
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset quotient", quotient, 64'd0);
    check("reset remainder", remainder, 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    start   = 1'b0;
    reset_n = 1'b1;

    // 100 / 7 with busy-length and hold checks.
    start_op(64'd100, 64'd7);
    check("100/7 busy at accept", 64'(busy), 64'd1);
    wait_done(0, lat, nbusy, overlap);
    check("100/7 latency", 64'(lat), 64'd64);
    check("100/7 busy cycles", 64'(nbusy), 64'd64);
    check("100/7 busy in done cycle", 64'(busy), 64'd0);
    check("100/7 quotient", quotient, 64'd14);
    check("100/7 remainder", remainder, 64'd2);
    check("100/7 div_by_zero", 64'(div_by_zero), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("100/7 hold done", 64'(done), 64'd0);
    check("100/7 hold quotient", quotient, 64'd14);
    check("100/7 hold remainder", remainder, 64'd2);

    // Boundaries.
    run_div("max/1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    run_div("5/9", 64'd5, 64'd9, 64, 64'd0, 64'd5, 1'b0);
    run_div("msb/max", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64,
            64'd0, 64'h8000_0000_0000_0000, 1'b0);

    // Divide by zero, then a normal division clears the flag.
    run_div("1234/0", 64'd1234, 64'd0, 1, 64'd0, 64'd1234, 1'b1);
    run_div("10/3", 64'd10, 64'd3, 64, 64'd3, 64'd1, 1'b0);

    // start during RUN is ignored.
    start_op(64'd50, 64'd5);
    repeat (9) @(posedge clk);
    start_op(64'd9, 64'd2);
    check("ignored start busy", 64'(busy), 64'd1);
    wait_done(10, lat, nbusy, overlap);
    check("50/5 latency", 64'(lat), 64'd64);
    check("50/5 quotient", quotient, 64'd10);
    check("50/5 remainder", remainder, 64'd0);

    // Back-to-back start in the done cycle.
    start_op(64'd9, 64'd2);
    check("b2b busy", 64'(busy), 64'd1);
    check("b2b done fell", 64'(done), 64'd0);
    check("b2b results cleared", quotient, 64'd0);
    wait_done(0, lat, nbusy, overlap);
    check("9/2 latency", 64'(lat), 64'd64);
    check("9/2 quotient", quotient, 64'd4);
    check("9/2 remainder", remainder, 64'd1);

    // Reset mid-run abandons the division.
    start_op(64'd1000, 64'd3);
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst quotient", quotient, 64'd0);
    check("midrst remainder", remainder, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    seen_done = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done++;
    end
    check("midrst no done", 64'(seen_done), 64'd0);
    run_div("9/3", 64'd9, 64'd3, 64, 64'd3, 64'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
